// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : Control/status bundle between the datapath and the fetch controller.
// Revision : 1.0
// ============================================================================
interface fetch_ctrl_if #(
    parameter int PC_W = 16
);
    logic            start;
    logic            halt;
    logic            stall;
    logic            branch_en;
    logic            branch_abs;
    logic [7:0]      branch_off;
    logic [PC_W-1:0] branch_tgt;
    logic [PC_W-1:0] PC;
    logic            fetch_valid;
    logic            done;
    logic [15:0]     inst_count;

    // Datapath / sequencer side
    modport master (
        output start, halt, stall, branch_en, branch_abs, branch_off, branch_tgt,
        input  PC, fetch_valid, done, inst_count
    );

    // Fetch controller side
    modport slave (
        input  start, halt, stall, branch_en, branch_abs, branch_off, branch_tgt,
        output PC, fetch_valid, done, inst_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : IDLE/RUN/HALT program-counter sequencer with branches and stalls.
// Revision : 1.0
// ============================================================================
module fetch_ctrl #(
    parameter int              PC_W       = 16,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  wire logic     CLK,
    input  wire logic     rst_n,
    fetch_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_fetch_valid;
    logic            r_done;
    logic [15:0]     r_inst_count;

    logic [PC_W-1:0] w_rel_tgt;
    logic [15:0]     w_count_inc;

    assign w_rel_tgt   = r_pc + {{(PC_W-8){bus.branch_off[7]}}, bus.branch_off};
    assign w_count_inc = (r_inst_count == 16'hFFFF) ? r_inst_count : r_inst_count + 16'd1;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= START_ADDR;
            r_fetch_valid <= 1'b0;
            r_done        <= 1'b0;
            r_inst_count  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state       <= S_RUN;
                        r_pc          <= START_ADDR;
                        r_inst_count  <= 16'd0;
                        r_fetch_valid <= 1'b1;
                        r_done        <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Priority: halt > stall > branch > sequential increment
                    if (bus.halt) begin
                        r_state       <= S_HALT;
                        r_inst_count  <= w_count_inc;
                        r_fetch_valid <= 1'b0;
                        r_done        <= 1'b1;
                    end else if (!bus.stall) begin
                        r_inst_count <= w_count_inc;
                        if (bus.branch_en)
                            r_pc <= bus.branch_abs ? bus.branch_tgt : w_rel_tgt;
                        else
                            r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
                    end
                end
                S_HALT: begin
                    if (bus.start) begin
                        r_state       <= S_RUN;
                        r_pc          <= START_ADDR;
                        r_inst_count  <= 16'd0;
                        r_fetch_valid <= 1'b1;
                        r_done        <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_pc          <= START_ADDR;
                    r_fetch_valid <= 1'b0;
                    r_done        <= 1'b0;
                    r_inst_count  <= 16'd0;
                end
            endcase
        end
    end

    assign bus.PC          = r_pc;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.done        = r_done;
    assign bus.inst_count  = r_inst_count;
endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl.
// Revision : 1.0
// ============================================================================
module tb_fetch_ctrl;
    logic CLK;
    logic rst_n;
    int   total;
    int   bad;

    fetch_ctrl_if #(.PC_W(16)) bus ();

    fetch_ctrl #(.PC_W(16), .START_ADDR(16'h0000)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] pc, input logic fv,
                           input logic dn, input logic [15:0] cnt);
        chk({tag, ".pc"},    {16'd0, bus.PC},         {16'd0, pc});
        chk({tag, ".fv"},    {31'd0, bus.fetch_valid}, {31'd0, fv});
        chk({tag, ".done"},  {31'd0, bus.done},        {31'd0, dn});
        chk({tag, ".count"}, {16'd0, bus.inst_count}, {16'd0, cnt});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start      = 1'b0;
        bus.halt       = 1'b0;
        bus.stall      = 1'b0;
        bus.branch_en  = 1'b0;
        bus.branch_abs = 1'b0;
        bus.branch_off = 8'h00;
        bus.branch_tgt = 16'h0000;

        #2;
        chk_all("reset", 16'h0000, 1'b0, 1'b0, 16'd0);
        step();
        step();
        rst_n = 1'b1;
        // Noise on halt/stall/branch in IDLE must be ignored
        bus.halt = 1'b1; bus.stall = 1'b1; bus.branch_en = 1'b1; bus.branch_abs = 1'b1;
        bus.branch_tgt = 16'h1234;
        step();
        chk_all("idle_noise", 16'h0000, 1'b0, 1'b0, 16'd0);
        bus.halt = 1'b0; bus.stall = 1'b0; bus.branch_en = 1'b0; bus.branch_abs = 1'b0;

        // Start, then free run
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_all("run0", 16'h0000, 1'b1, 1'b0, 16'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_all("free", 16'(i), 1'b1, 1'b0, 16'(i));
        end
        // start ignored in RUN
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_all("start_in_run", 16'h0006, 1'b1, 1'b0, 16'd6);

        // Relative branch backwards by 3
        bus.branch_en = 1'b1; bus.branch_abs = 1'b0; bus.branch_off = 8'hFD;
        step();
        chk_all("rel_br", 16'h0003, 1'b1, 1'b0, 16'd7);
        bus.branch_abs = 1'b1; bus.branch_tgt = 16'h0100;
        step();
        chk_all("abs_br", 16'h0100, 1'b1, 1'b0, 16'd8);
        // Forward relative branch
        bus.branch_abs = 1'b0; bus.branch_off = 8'h10;
        step();
        chk_all("rel_fwd", 16'h0110, 1'b1, 1'b0, 16'd9);
        bus.branch_abs = 1'b1; bus.branch_tgt = 16'h0009;
        step();
        chk_all("to9", 16'h0009, 1'b1, 1'b0, 16'd10);

        // Stall beats branch
        bus.stall = 1'b1; bus.branch_tgt = 16'h0777;
        step();
        chk_all("stall1", 16'h0009, 1'b1, 1'b0, 16'd10);
        step();
        chk_all("stall2", 16'h0009, 1'b1, 1'b0, 16'd10);
        // Halt beats stall; halt instruction counted
        bus.halt = 1'b1;
        step();
        chk_all("halt", 16'h0009, 1'b0, 1'b1, 16'd11);
        bus.stall = 1'b0;
        step();
        chk_all("halt_hold", 16'h0009, 1'b0, 1'b1, 16'd11);
        bus.halt = 1'b0; bus.branch_en = 1'b0;

        // Restart from HALT
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_all("restart", 16'h0000, 1'b1, 1'b0, 16'd0);

        // PC wrap
        bus.branch_en = 1'b1; bus.branch_abs = 1'b1; bus.branch_tgt = 16'hFFFF;
        step();
        bus.branch_en = 1'b0;
        chk_all("to_ffff", 16'hFFFF, 1'b1, 1'b0, 16'd1);
        step();
        chk_all("wrap", 16'h0000, 1'b1, 1'b0, 16'd2);

        // Relative wrap below zero
        bus.branch_en = 1'b1; bus.branch_abs = 1'b0; bus.branch_off = 8'h80;
        step();
        bus.branch_en = 1'b0;
        chk_all("rel_wrap", 16'hFF80, 1'b1, 1'b0, 16'd3);

        // Count saturation: 65540 more free cycles
        repeat (65540) step();
        chk({"sat", ".count"}, {16'd0, bus.inst_count}, 32'h0000FFFF);
        chk({"sat", ".pc"}, {16'd0, bus.PC}, 32'h0000FF80 + 32'd65540 - 32'h00010000);
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        chk({"sat_halt", ".count"}, {16'd0, bus.inst_count}, 32'h0000FFFF);
        chk({"sat_halt", ".done"}, {31'd0, bus.done}, 32'd1);

        // Restart, go to 0x42, asynchronous reset between edges
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.branch_en = 1'b1; bus.branch_abs = 1'b1; bus.branch_tgt = 16'h0042;
        step();
        bus.branch_en = 1'b0;
        chk_all("to42", 16'h0042, 1'b1, 1'b0, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 16'h0000, 1'b0, 1'b0, 16'd0);
        #1;
        rst_n = 1'b1;
        step();
        chk_all("idle_after_rst", 16'h0000, 1'b0, 1'b0, 16'd0);
        step();
        chk_all("idle_wait", 16'h0000, 1'b0, 1'b0, 16'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk_all("run_after_rst", 16'h0001, 1'b1, 1'b0, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_W, default 16: program-counter width; matches the instruction ROM address width.
REQ-002 Parameter START_ADDR, default 0: PC value loaded at reset and at every program (re)start.
REQ-003 Port CLK, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: request to begin, or restart, program execution.
REQ-006 Port halt, input, 1: decoded halt instruction at the current PC.
REQ-007 Port stall, input, 1: hold the PC for this cycle (datapath busy).
REQ-008 Port branch_en, input, 1: taken branch for the instruction at the current PC.
REQ-009 Port branch_abs, input, 1: 1 = absolute target; 0 = PC-relative offset.
REQ-010 Port branch_off, input, 8: signed two's-complement relative offset.
REQ-011 Port branch_tgt, input, PC_W: absolute branch target.
REQ-012 Port PC, output, PC_W: instruction ROM address; registered.
REQ-013 Port fetch_valid, output, 1: the ROM output at PC is a live instruction; high only in RUN.
REQ-014 Port done, output, 1: program has halted; registered.
REQ-015 Port inst_count, output, 16: instructions retired since the last start; registered.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN, HALT; output decode is Moore.
REQ-017 IDLE: PC = START_ADDR, fetch_valid = 0, done = 0; start = 1 moves to RUN at the next edge.
REQ-018 RUN: fetch_valid = 1; the next PC is chosen by fixed priority halt > stall > branch_en > increment.
REQ-019 RUN with halt = 1: go to HALT; PC holds; inst_count increments once, counting the halt instruction; done = 1 from the next cycle.
REQ-020 RUN with stall = 1 and halt = 0: PC and inst_count hold; branch_en is ignored that cycle.
REQ-021 RUN with branch_en = 1 and branch_abs = 1: PC <= branch_tgt.
REQ-022 RUN with branch_en = 1 and branch_abs = 0: PC <= PC + sign-extended branch_off, modulo 2^PC_W.
REQ-023 RUN with no halt, stall or branch: PC <= PC + 1 modulo 2^PC_W; all-ones wraps to 0 with no flag.
REQ-024 Every non-stalled RUN cycle SHALL increment inst_count, saturating at 16'hFFFF.
REQ-025 start SHALL be ignored in RUN.
REQ-026 HALT: done = 1, fetch_valid = 0, PC and inst_count frozen; halt, stall and branch inputs are ignored.
REQ-027 HALT with start = 1: PC <= START_ADDR, inst_count <= 0, done <= 0, go to RUN at the next edge.
REQ-028 In IDLE and HALT, the branch, halt and stall inputs SHALL have no effect on any output.
REQ-029 Branch latency SHALL be one cycle: the target appears on PC at the edge after branch_en is sampled, with no bubble.

Reset
REQ-030 rst_n = 0 SHALL immediately, without a clock, force state IDLE, PC = START_ADDR, fetch_valid = 0, done = 0, inst_count = 0.
REQ-031 Reset asserted mid-RUN or in HALT SHALL abandon execution; after release the block waits in IDLE for start.
REQ-032 Deassertion of rst_n is synchronized externally; the first edge with rst_n = 1 evaluates IDLE rules normally.

Verification
REQ-033 Reset, then start for 1 cycle, then 5 free cycles -> PC 0,1,2,3,4,5; fetch_valid = 1 from the first RUN cycle; inst_count = 5.
REQ-034 At PC = 6, branch_en = 1, branch_abs = 0, branch_off = 8'hFD -> PC = 3 next cycle. At PC = 3, branch_abs = 1, branch_tgt = 16'h0100 -> PC = 16'h0100.
REQ-035 At PC = 9: stall = 1 for 2 cycles with branch_en = 1, then halt = 1 with stall = 1 -> PC stays 9, state HALT, done = 1, inst_count frozen.
REQ-036 Force PC = 16'hFFFF via an absolute branch, then 1 free cycle -> PC = 0. In HALT, assert start -> PC = 0, done = 0, inst_count = 0, state RUN.
REQ-037 Pulse rst_n low between clock edges while PC = 16'h0042 -> PC = 0, fetch_valid = 0 and done = 0 before the next edge; the block stays in IDLE until start.
